// File: rtl/if_stage_if.sv
// Instruction-memory request/response bundle between the fetch stage and imem.
// Master issues single-outstanding word requests; slave answers with ack + data.
interface if_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/if_stage.sv
// RV32I fetch stage: PC, single-outstanding imem request, IF/ID register, stall skid and redirect.
// Latency: ack at cycle N is on IF/ID at N+1. Optional IF_PERF_CNT_EN adds fetch/bubble counters.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic          clk,
    input  logic          rst,
    if_stage_if.master    imem,
    input  logic          stall_d_i,
    input  logic          PCsrc_i,
    input  logic [31:0]   br_target_i,
    output logic [31:0]   Inst_d_o,
    output logic [31:0]   pc_d_o,
    output logic [31:0]   pc4_d_o,
    output logic          valid_d_o
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]   fetch_cnt_o,
    output logic [31:0]   bubble_cnt_o
`endif
);

    typedef enum logic [1:0] {FETCH, HOLD, DROP} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_f_q, pc_f_d;
    logic [31:0] drop_addr_q, drop_addr_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [31:0] skid_inst_q, skid_inst_d;
    logic [31:0] skid_pc_q, skid_pc_d;

    logic        ack;
    logic        accepted;
    logic [31:0] pc_f_plus4;
    logic [31:0] target;

    assign imem.imem_req  = !rst && (state_q != HOLD);
    // DROP keeps presenting the abandoned address until its stale ack returns.
    assign imem.imem_addr = (state_q == DROP) ? drop_addr_q : pc_f_q;

    assign ack        = imem.imem_ack && imem.imem_req;
    assign accepted   = (state_q == FETCH) && ack && !PCsrc_i;
    assign pc_f_plus4 = pc_f_q + 32'd4;
    assign target     = br_target_i & ~32'd3;

    assign Inst_d_o  = inst_q;
    assign pc_d_o    = pc_q;
    assign pc4_d_o   = pc_q + 32'd4;
    assign valid_d_o = valid_q;

    always_comb begin
        state_d     = state_q;
        pc_f_d      = pc_f_q;
        drop_addr_d = drop_addr_q;
        inst_d      = inst_q;
        pc_d        = pc_q;
        valid_d     = valid_q;
        skid_inst_d = skid_inst_q;
        skid_pc_d   = skid_pc_q;

        if (PCsrc_i) begin
            valid_d = 1'b0;
            inst_d  = NOP_INST;
            pc_f_d  = target;
            case (state_q)
                FETCH: begin
                    if (!ack) begin
                        state_d     = DROP;
                        drop_addr_d = pc_f_q;
                    end
                end
                HOLD:    state_d = FETCH;
                DROP:    if (ack) state_d = FETCH;
                default: state_d = FETCH;
            endcase
        end else begin
            case (state_q)
                FETCH: begin
                    if (ack) begin
                        pc_f_d = pc_f_plus4;
                        if (stall_d_i) begin
                            skid_inst_d = imem.imem_rdata;
                            skid_pc_d   = pc_f_q;
                            state_d     = HOLD;
                        end else begin
                            inst_d  = imem.imem_rdata;
                            pc_d    = pc_f_q;
                            valid_d = 1'b1;
                        end
                    end else if (!stall_d_i) begin
                        valid_d = 1'b0;
                        inst_d  = NOP_INST;
                    end
                end
                HOLD: begin
                    if (!stall_d_i) begin
                        inst_d  = skid_inst_q;
                        pc_d    = skid_pc_q;
                        valid_d = 1'b1;
                        state_d = FETCH;
                    end
                end
                DROP: begin
                    if (ack) state_d = FETCH;
                    if (!stall_d_i) begin
                        valid_d = 1'b0;
                        inst_d  = NOP_INST;
                    end
                end
                default: state_d = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FETCH;
            pc_f_q      <= RESET_PC;
            drop_addr_q <= RESET_PC;
            inst_q      <= NOP_INST;
            pc_q        <= 32'd0;
            valid_q     <= 1'b0;
            skid_inst_q <= NOP_INST;
            skid_pc_q   <= 32'd0;
        end else begin
            state_q     <= state_d;
            pc_f_q      <= pc_f_d;
            drop_addr_q <= drop_addr_d;
            inst_q      <= inst_d;
            pc_q        <= pc_d;
            valid_q     <= valid_d;
            skid_inst_q <= skid_inst_d;
            skid_pc_q   <= skid_pc_d;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, bubble_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q  <= 32'd0;
            bubble_cnt_q <= 32'd0;
        end else begin
            if (accepted) fetch_cnt_q  <= fetch_cnt_q + 32'd1;
            if (!valid_q) bubble_cnt_q <= bubble_cnt_q + 32'd1;
        end
    end

    assign fetch_cnt_o  = fetch_cnt_q;
    assign bubble_cnt_o = bubble_cnt_q;
`else
    logic unused_accepted;
    assign unused_accepted = accepted;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios plus randomized traffic against a flag-based fetch model.
module tb_if_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, redir;
    logic [31:0] tgt;
    logic [31:0] inst, pcd, pc4;
    logic        vld;
    logic [31:0] w_inst, w_pcd, w_pc4;
    logic        w_vld;
`ifdef IF_PERF_CNT_EN
    logic [31:0] fcnt, bcnt, w_fcnt, w_bcnt;
`endif

    always #5 clk = ~clk;

    if_stage_if bus ();
    if_stage_if wbus ();

    assign wbus.imem_ack   = wbus.imem_req;
    assign wbus.imem_rdata = 32'h1234_5678;

    if_stage dut (
        .clk(clk), .rst(rst), .imem(bus.master),
        .stall_d_i(stall), .PCsrc_i(redir), .br_target_i(tgt),
        .Inst_d_o(inst), .pc_d_o(pcd), .pc4_d_o(pc4), .valid_d_o(vld)
`ifdef IF_PERF_CNT_EN
        , .fetch_cnt_o(fcnt), .bubble_cnt_o(bcnt)
`endif
    );

    if_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst(rst), .imem(wbus.master),
        .stall_d_i(1'b0), .PCsrc_i(1'b0), .br_target_i(32'd0),
        .Inst_d_o(w_inst), .pc_d_o(w_pcd), .pc4_d_o(w_pc4), .valid_d_o(w_vld)
`ifdef IF_PERF_CNT_EN
        , .fetch_cnt_o(w_fcnt), .bubble_cnt_o(w_bcnt)
`endif
    );

    int compared   = 0;
    int mismatched = 0;

    // Reference model: next fetch PC, a full/empty skid, and a "discard next ack" flag.
    logic [31:0] m_pc, m_old, m_inst, m_pcd, m_skid_inst, m_skid_pc, m_fetch, m_bub;
    logic        m_v, m_skid_full, m_discard;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'd0; m_old = 32'd0; m_inst = NOP; m_pcd = 32'd0; m_v = 1'b0;
        m_skid_full = 1'b0; m_discard = 1'b0; m_skid_inst = 32'd0; m_skid_pc = 32'd0;
        m_fetch = 32'd0; m_bub = 32'd0;
    endtask

    task automatic model_update(input logic a, input logic [31:0] d, input logic s,
                                input logic r, input logic [31:0] t);
        if (!m_v) m_bub++;
        if (r) begin
            m_v = 1'b0; m_inst = NOP;
            if (m_skid_full) m_skid_full = 1'b0;
            else if (m_discard) m_discard = !a;
            else if (!a) begin m_discard = 1'b1; m_old = m_pc; end
            m_pc = t & ~32'h3;
        end else if (m_skid_full) begin
            if (!s) begin
                m_inst = m_skid_inst; m_pcd = m_skid_pc; m_v = 1'b1; m_skid_full = 1'b0;
            end
        end else if (m_discard) begin
            if (a) m_discard = 1'b0;
            if (!s) begin m_v = 1'b0; m_inst = NOP; end
        end else if (a) begin
            m_fetch++;
            if (s) begin m_skid_inst = d; m_skid_pc = m_pc; m_skid_full = 1'b1; end
            else begin m_inst = d; m_pcd = m_pc; m_v = 1'b1; end
            m_pc = m_pc + 32'd4;
        end else if (!s) begin
            m_v = 1'b0; m_inst = NOP;
        end
    endtask

    task automatic compare_bus(input string tag);
        chk({tag, ".req"}, {31'd0, bus.imem_req}, {31'd0, !m_skid_full});
        if (!m_skid_full) chk({tag, ".addr"}, bus.imem_addr, m_discard ? m_old : m_pc);
    endtask

    task automatic compare_regs(input string tag);
        chk({tag, ".inst"}, inst, m_inst);
        chk({tag, ".pc_d"}, pcd, m_pcd);
        chk({tag, ".pc4_d"}, pc4, m_pcd + 32'd4);
        chk({tag, ".valid"}, {31'd0, vld}, {31'd0, m_v});
`ifdef IF_PERF_CNT_EN
        chk({tag, ".fetch_cnt"}, fcnt, m_fetch);
        chk({tag, ".bubble_cnt"}, bcnt, m_bub);
`endif
    endtask

    task automatic step(input string tag, input logic a, input logic [31:0] d, input logic s,
                        input logic r, input logic [31:0] t);
        logic ea;
        ea = a && !m_skid_full;
        bus.imem_ack = ea; bus.imem_rdata = d; stall = s; redir = r; tgt = t;
        #1 compare_bus(tag);
        @(posedge clk);
        model_update(ea, d, s, r, t);
        @(negedge clk);
        compare_regs(tag);
    endtask

    task automatic do_reset();
        rst = 1'b1; bus.imem_ack = 1'b0; stall = 1'b0; redir = 1'b0; tgt = 32'd0;
        #1 chk("rst.req_low", {31'd0, bus.imem_req}, 32'd0);
        @(posedge clk);
        model_reset();
        @(negedge clk);
        compare_regs("rst");
        rst = 1'b0;
        #1 chk("rst.req_rise", {31'd0, bus.imem_req}, 32'd1);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; redir = 1'b0; tgt = 32'd0;
        bus.imem_ack = 1'b0; bus.imem_rdata = 32'd0;
        model_reset();
        @(negedge clk);

        // Back-to-back acks and wrapping instance
        do_reset();
        chk("rst.inst_nop", inst, NOP);
        chk("rst.pc4", pc4, 32'd4);
        chk("wrap.addr0", wbus.imem_addr, 32'hFFFF_FFFC);
        step("b2b0", 1'b1, 32'h0050_0093, 1'b0, 1'b0, 32'd0);
        chk("b2b0.inst", inst, 32'h0050_0093);
        chk("b2b0.pc_d", pcd, 32'h0);
        chk("wrap.addr1", wbus.imem_addr, 32'h0);
        chk("wrap.pc_d", w_pcd, 32'hFFFF_FFFC);
        chk("wrap.pc4", w_pc4, 32'h0);
        step("b2b1", 1'b1, 32'h00A0_0113, 1'b0, 1'b0, 32'd0);
        chk("b2b1.pc_d", pcd, 32'h4);
        chk("b2b1.valid", {31'd0, vld}, 32'd1);
        chk("b2b1.next_addr", bus.imem_addr, 32'h8);
`ifdef IF_PERF_CNT_EN
        chk("perf.fetch2", fcnt, 32'd2);
        chk("perf.bubble1", bcnt, 32'd1);
        do_reset();
        chk("perf.fetch_clr", fcnt, 32'd0);
        chk("perf.bubble_clr", bcnt, 32'd0);
`endif

        // Two-cycle memory latency
        do_reset();
        for (int i = 0; i < 6; i++)
            step("lat", (i % 2) == 1, 32'h1000_0000 + i, 1'b0, 1'b0, 32'd0);

        // Stall on ack at 0x8 for three cycles
        do_reset();
        step("stl0", 1'b1, 32'h0000_1111, 1'b0, 1'b0, 32'd0);
        step("stl1", 1'b1, 32'h0000_2222, 1'b0, 1'b0, 32'd0);
        step("stl2", 1'b1, 32'h0000_3333, 1'b1, 1'b0, 32'd0);
        chk("stl2.req_hold", {31'd0, bus.imem_req}, 32'd0);
        chk("stl2.held_pc", pcd, 32'h4);
        step("stl3", 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
        step("stl4", 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
        step("stl5", 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        chk("stl5.skid_inst", inst, 32'h0000_3333);
        chk("stl5.skid_pc", pcd, 32'h8);
        chk("stl5.next_addr", bus.imem_addr, 32'hC);

        // Redirect while request pending -> stale ack dropped
        do_reset();
        for (int i = 0; i < 4; i++) step("pre", 1'b1, 32'h2000_0000 + i, 1'b0, 1'b0, 32'd0);
        step("drp0", 1'b0, 32'd0, 1'b0, 1'b1, 32'h0000_0103);
        chk("drp0.old_addr", bus.imem_addr, 32'h10);
        step("drp1", 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'd0);
        chk("drp1.valid", {31'd0, vld}, 32'd0);
        chk("drp1.new_addr", bus.imem_addr, 32'h100);
        step("drp2", 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        step("drp3", 1'b1, 32'h0010_0073, 1'b0, 1'b0, 32'd0);
        chk("drp3.pc_d", pcd, 32'h100);
        chk("drp3.inst", inst, 32'h0010_0073);

        // Flush beats stall in HOLD
        do_reset();
        step("fl0", 1'b1, 32'h0000_AAAA, 1'b0, 1'b0, 32'd0);
        step("fl1", 1'b1, 32'h0000_BBBB, 1'b1, 1'b0, 32'd0);
        step("fl2", 1'b0, 32'd0, 1'b1, 1'b1, 32'h0000_0200);
        chk("fl2.valid", {31'd0, vld}, 32'd0);
        chk("fl2.inst", inst, NOP);
        chk("fl2.addr", bus.imem_addr, 32'h200);
        step("fl3", 1'b1, 32'h0000_CCCC, 1'b0, 1'b0, 32'd0);
        chk("fl3.pc_d", pcd, 32'h200);

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 99) == 0) do_reset();
            else step("rnd", $urandom_range(0, 99) < 60, $urandom, $urandom_range(0, 99) < 25,
                      $urandom_range(0, 99) < 10, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
